ex_mem_stage: RTL and testbench

//  EX->MEM boundary stage directly downstream of the ALU. Registers ALU_result/ALU_zero plus EX control.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/ex_mem_stage_ack_timer.sv | 43 ++++
 rtl/ex_mem_stage.sv | 207 ++++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS EX->MEM boundary stage.
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_REG_AW = 5;

  typedef enum logic {
    IDLE = 1'b0,
    MEM  = 1'b1
  } ex_mem_state_t;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_MISALIGN = 2'd1,
    EXC_TIMEOUT  = 2'd2
  } exc_code_t;

  // Word accesses must have a zero byte offset.
  function automatic logic word_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/ex_mem_stage_ack_timer.sv
// Counts cycles a memory request has waited; expired flags the last allowed cycle.
module ack_timer
  import mips_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RESET,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear on a new request, advance while waiting for ack.
  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of request cycles already elapsed before this one.
  assign expired = (count_q == CNT_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM stage: branch resolution, load/store over req/ack, and one write-back record per instruction.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W      = MIPS_DATA_W,
  parameter int REG_AW      = MIPS_REG_AW,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EX_valid,
  output logic              EX_ready,
  input  logic [DATA_W-1:0] EX_ALU_result,
  input  logic              EX_ALU_zero,
  input  logic [DATA_W-1:0] EX_write_data,
  input  logic [REG_AW-1:0] EX_rd,
  input  logic              EX_RegWrite,
  input  logic              EX_MemRead,
  input  logic              EX_MemWrite,
  input  logic              EX_MemtoReg,
  input  logic              EX_Branch,
  input  logic [DATA_W-1:0] EX_branch_target,
  output logic              PCSrc,
  output logic [DATA_W-1:0] PC_branch,
  output logic              MEM_req,
  output logic              MEM_we,
  output logic [DATA_W-1:0] MEM_addr,
  output logic [DATA_W-1:0] MEM_wdata,
  input  logic              MEM_ack,
  input  logic [DATA_W-1:0] MEM_rdata,
  output logic              WB_valid,
  output logic              WB_RegWrite,
  output logic [REG_AW-1:0] WB_rd,
  output logic [DATA_W-1:0] WB_data,
  output logic              WB_exc
);

  ex_mem_state_t     state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic              pcsrc_q, pcsrc_d;
  logic [DATA_W-1:0] pc_branch_q, pc_branch_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              wb_exc_q, wb_exc_d;
  exc_code_t         exc_code;
  logic              accept;
  logic              is_mem;
  logic              timer_start;
  logic              timer_run;
  logic              timer_expired;

  assign EX_ready  = (state_q == IDLE);
  assign accept    = EX_valid & EX_ready;
  assign is_mem    = EX_MemRead | EX_MemWrite;
  assign timer_run = (state_q == MEM) & ~MEM_ack;

  ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .start  (timer_start),
    .run    (timer_run),
    .expired(timer_expired)
  );

  // Next-state and next-output logic; pulses default low, data outputs hold.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rd_d          = rd_q;
    regwrite_d    = regwrite_q;
    memtoreg_d    = memtoreg_q;
    pcsrc_d       = 1'b0;
    pc_branch_d   = pc_branch_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    exc_code      = EXC_NONE;
    timer_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (EX_Branch) begin
            pcsrc_d     = EX_ALU_zero;
            pc_branch_d = EX_branch_target;
          end else begin
            pcsrc_d = 1'b0;
          end
          if (!is_mem) begin
            wb_valid_d    = 1'b1;
            wb_regwrite_d = EX_RegWrite & ~EX_Branch;
            wb_rd_d       = EX_rd;
            wb_data_d     = EX_ALU_result;
          end else if (word_misaligned(EX_ALU_result[1:0])) begin
            // Faulting address is reported in the write-back data.
            wb_valid_d = 1'b1;
            exc_code   = EXC_MISALIGN;
            wb_rd_d    = EX_rd;
            wb_data_d  = EX_ALU_result;
          end else begin
            state_d     = MEM;
            mem_req_d   = 1'b1;
            mem_we_d    = EX_MemWrite;
            mem_addr_d  = EX_ALU_result;
            mem_wdata_d = EX_write_data;
            rd_d        = EX_rd;
            regwrite_d  = EX_RegWrite;
            memtoreg_d  = EX_MemtoReg;
            timer_start = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MEM: begin
        if (MEM_ack) begin
          state_d       = IDLE;
          mem_req_d     = 1'b0;
          mem_we_d      = 1'b0;
          wb_valid_d    = 1'b1;
          wb_regwrite_d = regwrite_q & ~mem_we_q;
          wb_rd_d       = rd_q;
          wb_data_d     = memtoreg_q ? MEM_rdata : mem_addr_q;
        end else if (timer_expired) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          wb_valid_d = 1'b1;
          exc_code   = EXC_TIMEOUT;
          wb_rd_d    = rd_q;
          wb_data_d  = mem_addr_q;
        end else begin
          state_d = MEM;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
    wb_exc_d = (exc_code != EXC_NONE);
  end

  // State and output registers; reset drops any in-flight access silently.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd_q          <= '0;
      regwrite_q    <= 1'b0;
      memtoreg_q    <= 1'b0;
      pcsrc_q       <= 1'b0;
      pc_branch_q   <= '0;
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      wb_exc_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_q          <= rd_d;
      regwrite_q    <= regwrite_d;
      memtoreg_q    <= memtoreg_d;
      pcsrc_q       <= pcsrc_d;
      pc_branch_q   <= pc_branch_d;
      wb_valid_q    <= wb_valid_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      wb_exc_q      <= wb_exc_d;
    end
  end

  assign PCSrc       = pcsrc_q;
  assign PC_branch   = pc_branch_q;
  assign MEM_req     = mem_req_q;
  assign MEM_we      = mem_we_q;
  assign MEM_addr    = mem_addr_q;
  assign MEM_wdata   = mem_wdata_q;
  assign WB_valid    = wb_valid_q;
  assign WB_RegWrite = wb_regwrite_q;
  assign WB_rd       = wb_rd_q;
  assign WB_data     = wb_data_q;
  assign WB_exc      = wb_exc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized ops against a rule-based model.
module tb_ex_mem_stage;

  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int ACK_TO = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          EX_valid;
  logic          EX_ready;
  logic [DW-1:0] EX_ALU_result;
  logic          EX_ALU_zero;
  logic [DW-1:0] EX_write_data;
  logic [AW-1:0] EX_rd;
  logic          EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_Branch;
  logic [DW-1:0] EX_branch_target;
  logic          PCSrc;
  logic [DW-1:0] PC_branch;
  logic          MEM_req, MEM_we;
  logic [DW-1:0] MEM_addr, MEM_wdata;
  logic          MEM_ack;
  logic [DW-1:0] MEM_rdata;
  logic          WB_valid, WB_RegWrite;
  logic [AW-1:0] WB_rd;
  logic [DW-1:0] WB_data;
  logic          WB_exc;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_stage #(.DATA_W(DW), .REG_AW(AW), .ACK_TIMEOUT(ACK_TO)) dut (
    .CLK(CLK), .RESET(RESET), .EX_valid(EX_valid), .EX_ready(EX_ready),
    .EX_ALU_result(EX_ALU_result), .EX_ALU_zero(EX_ALU_zero), .EX_write_data(EX_write_data),
    .EX_rd(EX_rd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_MemtoReg(EX_MemtoReg), .EX_Branch(EX_Branch), .EX_branch_target(EX_branch_target),
    .PCSrc(PCSrc), .PC_branch(PC_branch), .MEM_req(MEM_req), .MEM_we(MEM_we),
    .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata), .MEM_ack(MEM_ack), .MEM_rdata(MEM_rdata),
    .WB_valid(WB_valid), .WB_RegWrite(WB_RegWrite), .WB_rd(WB_rd), .WB_data(WB_data),
    .WB_exc(WB_exc)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one instruction starting #1 after a rising edge; ack_lat = request cycle that acks (0 = none).
  task automatic run_op(input logic [31:0] alu, input logic zero, input logic [31:0] wdata,
                        input logic [4:0] rd, input logic regw, input logic mrd, input logic mwr,
                        input logic m2r, input logic br, input logic [31:0] tgt,
                        input int ack_lat, input logic stray_ack);
    logic        is_mem, mis, got_ack;
    logic [31:0] rdata_sent;
    logic [31:0] exp_data;
    logic        exp_rw;
    is_mem     = mrd | mwr;
    mis        = is_mem && (alu % 4 != 0);
    got_ack    = 1'b0;
    rdata_sent = 32'd0;
    EX_valid = 1'b1; EX_ALU_result = alu; EX_ALU_zero = zero; EX_write_data = wdata;
    EX_rd = rd; EX_RegWrite = regw; EX_MemRead = mrd; EX_MemWrite = mwr;
    EX_MemtoReg = m2r; EX_Branch = br; EX_branch_target = tgt;
    check("ready_before_accept", 32'(EX_ready), 32'd1);
    @(posedge CLK); #1;
    EX_valid = 1'b0;
    if (is_mem && !mis) begin
      for (int c = 1; c <= ACK_TO; c++) begin
        MEM_ack   = (c == ack_lat);
        MEM_rdata = $urandom;
        if (MEM_ack) rdata_sent = MEM_rdata;
        @(negedge CLK);
        check("mem_req_high", 32'(MEM_req), 32'd1);
        check("ready_low_in_mem", 32'(EX_ready), 32'd0);
        check("mem_addr_stable", MEM_addr, alu);
        check("mem_we", 32'(MEM_we), 32'(mwr));
        check("mem_wdata", MEM_wdata, wdata);
        check("no_wb_in_mem", 32'(WB_valid), 32'd0);
        got_ack = MEM_ack;
        @(posedge CLK); #1;
        MEM_ack = 1'b0;
        if (got_ack) break;
      end
    end
    @(negedge CLK);
    check("wb_valid", 32'(WB_valid), 32'd1);
    check("wb_rd", 32'(WB_rd), 32'(rd));
    check("mem_req_low_after", 32'(MEM_req), 32'd0);
    check("ready_after", 32'(EX_ready), 32'd1);
    if (br) begin
      check("pcsrc", 32'(PCSrc), 32'(zero));
      check("pc_branch", PC_branch, tgt);
    end else begin
      check("pcsrc_nobranch", 32'(PCSrc), 32'd0);
    end
    if (!is_mem) begin
      exp_rw = regw && !br;
      check("wb_exc_alu", 32'(WB_exc), 32'd0);
      check("wb_regwrite_alu", 32'(WB_RegWrite), 32'(exp_rw));
      check("wb_data_alu", WB_data, alu);
    end else if (mis || !got_ack) begin
      check("wb_exc", 32'(WB_exc), 32'd1);
      check("wb_regwrite_exc", 32'(WB_RegWrite), 32'd0);
    end else begin
      exp_rw   = regw && !mwr;
      exp_data = m2r ? rdata_sent : alu;
      check("wb_exc_mem", 32'(WB_exc), 32'd0);
      check("wb_regwrite_mem", 32'(WB_RegWrite), 32'(exp_rw));
      check("wb_data_mem", WB_data, exp_data);
    end
    @(posedge CLK); #1;
    MEM_ack   = stray_ack;
    MEM_rdata = 32'h0000_1234;
    @(negedge CLK);
    check("wb_pulse_1cyc", 32'(WB_valid), 32'd0);
    check("pcsrc_pulse_1cyc", 32'(PCSrc), 32'd0);
    @(posedge CLK); #1;
    MEM_ack = 1'b0;
    @(negedge CLK);
    check("idle_ack_ignored", 32'(WB_valid), 32'd0);
    check("idle_no_req", 32'(MEM_req), 32'd0);
    @(posedge CLK); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pcsrc"}, 32'(PCSrc), 32'd0);
    check({tag, "_pc_branch"}, PC_branch, 32'd0);
    check({tag, "_mem_req"}, 32'(MEM_req), 32'd0);
    check({tag, "_mem_we"}, 32'(MEM_we), 32'd0);
    check({tag, "_mem_addr"}, MEM_addr, 32'd0);
    check({tag, "_mem_wdata"}, MEM_wdata, 32'd0);
    check({tag, "_wb_valid"}, 32'(WB_valid), 32'd0);
    check({tag, "_wb_regwrite"}, 32'(WB_RegWrite), 32'd0);
    check({tag, "_wb_rd"}, 32'(WB_rd), 32'd0);
    check({tag, "_wb_data"}, WB_data, 32'd0);
    check({tag, "_wb_exc"}, 32'(WB_exc), 32'd0);
    check({tag, "_ready"}, 32'(EX_ready), 32'd1);
  endtask

  initial begin
    int          kind;
    logic [31:0] a;
    logic        rw, mr, mw;
    RESET = 1'b0; EX_valid = 1'b0; EX_ALU_result = 32'd0; EX_ALU_zero = 1'b0;
    EX_write_data = 32'd0; EX_rd = 5'd0; EX_RegWrite = 1'b0; EX_MemRead = 1'b0;
    EX_MemWrite = 1'b0; EX_MemtoReg = 1'b0; EX_Branch = 1'b0; EX_branch_target = 32'd0;
    MEM_ack = 1'b0; MEM_rdata = 32'd0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    check_all_zero("reset");
    @(posedge CLK); #1;

    // add, lw with 3-cycle ack, misaligned sw, taken / not-taken beq, timeout with late ack
    run_op(32'h0000_0005, 1'b0, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 1'b0);
    run_op(32'h0000_0010, 1'b0, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 3, 1'b0);
    run_op(32'h0000_0013, 1'b0, 32'hCAFE_0001, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1, 1'b0);
    run_op(32'h0000_0000, 1'b1, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0020, 0, 1'b0);
    run_op(32'h0000_0004, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0040, 0, 1'b0);
    run_op(32'h0000_0020, 1'b0, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 0, 1'b1);
    run_op(32'h0000_0024, 1'b0, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, ACK_TO, 1'b0);
    run_op(32'h0000_0028, 1'b0, 32'h1111_2222, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1, 1'b0);

    // back-to-back non-memory ops
    EX_valid = 1'b1; EX_ALU_result = 32'h0000_00AA; EX_rd = 5'd1; EX_RegWrite = 1'b1;
    EX_MemRead = 1'b0; EX_MemWrite = 1'b0; EX_Branch = 1'b0;
    @(posedge CLK); #1;
    EX_ALU_result = 32'h0000_00BB; EX_rd = 5'd2;
    @(negedge CLK);
    check("b2b_first_valid", 32'(WB_valid), 32'd1);
    check("b2b_first_data", WB_data, 32'h0000_00AA);
    check("b2b_ready", 32'(EX_ready), 32'd1);
    @(posedge CLK); #1;
    EX_valid = 1'b0;
    @(negedge CLK);
    check("b2b_second_valid", 32'(WB_valid), 32'd1);
    check("b2b_second_data", WB_data, 32'h0000_00BB);
    check("b2b_second_rd", 32'(WB_rd), 32'd2);
    @(posedge CLK); #1;

    // reset while a load is outstanding, then an ack while idle
    EX_valid = 1'b1; EX_ALU_result = 32'h0000_0040; EX_rd = 5'd7; EX_MemRead = 1'b1;
    EX_MemtoReg = 1'b1;
    @(posedge CLK); #1;
    EX_valid = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    check_all_zero("mid_mem_reset");
    @(posedge CLK); #1;
    MEM_ack = 1'b1; MEM_rdata = 32'h0000_1234;
    @(posedge CLK); #1;
    MEM_ack = 1'b0;
    @(negedge CLK);
    check("post_reset_ack_no_wb", 32'(WB_valid), 32'd0);
    check("post_reset_ack_data", WB_data, 32'd0);
    @(posedge CLK); #1;

    // randomized mix of ALU ops, branches, loads and stores
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 3);
      a    = $urandom;
      rw   = 1'($urandom_range(0, 1));
      mr   = 1'b0;
      mw   = 1'b0;
      if (kind >= 2) begin
        a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        mr     = (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        mw     = (kind == 3);
      end
      run_op(a, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), rw, mr, mw,
             1'($urandom_range(0, 1)), (kind == 1), $urandom, $urandom_range(0, 6),
             1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
